// File: rtl/fir_filter.sv
// fir_filter: direct-form FIR with a runtime-loadable coefficient bank.
// Ports:
//   clk, reset             clock and async active-high reset
//   s_axis_fir_tdata       signed sample in, or coefficient in load mode
//   s_axis_fir_tvalid      input sample valid
//   s_set_coeffs           coefficient-load mode enable
//   s_axis_fir_tready      downstream ready / sample-path advance enable
//   m_axis_fir_tdata       registered 32-bit signed filter output
//   m_axis_fir_tvalid      registered one-cycle valid per accepted sample
//   m_axis_fir_tkeep       byte enables, constant all-ones
module fir_filter #(
    parameter int NTAPS = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic signed [15:0] s_axis_fir_tdata,
    input  logic               s_axis_fir_tvalid,
    input  logic               s_set_coeffs,
    input  logic               s_axis_fir_tready,
    output logic signed [31:0] m_axis_fir_tdata,
    output logic               m_axis_fir_tvalid,
    output logic [3:0]         m_axis_fir_tkeep
);

    localparam int PW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam logic [PW-1:0] LAST = PW'(NTAPS - 1);

    logic signed [15:0] coef [NTAPS];
    logic signed [15:0] dly  [1:NTAPS-1];
    logic [PW-1:0]      ptr;
    logic               load_d;
    logic [PW-1:0]      wr_idx;
    logic               accept;
    logic signed [31:0] acc;

    // A fresh load period always starts writing at c[0].
    assign wr_idx = load_d ? ptr : '0;

    // Load mode wins over sample acceptance.
    assign accept = s_axis_fir_tvalid & s_axis_fir_tready & ~s_set_coeffs;

    assign m_axis_fir_tkeep = 4'hF;

    // Products are formed at 32 bits; the sum wraps modulo 2^32.
    always_comb begin
        acc = 32'(coef[0]) * 32'(s_axis_fir_tdata);
        for (int k = 1; k < NTAPS; k++) begin
            acc = acc + 32'(coef[k]) * 32'(dly[k]);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NTAPS; k++) begin
                coef[k] <= '0;
            end
            for (int k = 1; k < NTAPS; k++) begin
                dly[k] <= '0;
            end
            ptr               <= '0;
            load_d            <= 1'b0;
            m_axis_fir_tdata  <= '0;
            m_axis_fir_tvalid <= 1'b0;
        end else begin
            load_d            <= s_set_coeffs;
            m_axis_fir_tvalid <= accept;
            if (s_set_coeffs) begin
                coef[wr_idx] <= s_axis_fir_tdata;
                ptr <= (wr_idx == LAST) ? '0 : wr_idx + PW'(1);
            end
            if (accept) begin
                dly[1] <= s_axis_fir_tdata;
                for (int k = 2; k < NTAPS; k++) begin
                    dly[k] <= dly[k-1];
                end
                m_axis_fir_tdata <= acc;
            end
        end
    end

endmodule

// File: tb/tb_fir_filter.sv
// tb_fir_filter: directed and randomized checks of fir_filter against
// a queue-based convolution model of the filter.
module tb_fir_filter;

    localparam int NTAPS = 8;

    logic               clk;
    logic               reset;
    logic signed [15:0] s_axis_fir_tdata;
    logic               s_axis_fir_tvalid;
    logic               s_set_coeffs;
    logic               s_axis_fir_tready;
    logic signed [31:0] m_axis_fir_tdata;
    logic               m_axis_fir_tvalid;
    logic [3:0]         m_axis_fir_tkeep;

    int errors = 0;
    int checks = 0;

    // Reference model state
    logic signed [15:0] c_m [NTAPS];
    logic signed [15:0] hist [$];   // most recent accepted sample first
    int                 load_cnt;   // writes so far in current load period
    logic               set_prev;
    logic [31:0]        out_m;
    logic               vld_m;

    fir_filter #(.NTAPS(NTAPS)) dut (
        .clk               (clk),
        .reset             (reset),
        .s_axis_fir_tdata  (s_axis_fir_tdata),
        .s_axis_fir_tvalid (s_axis_fir_tvalid),
        .s_set_coeffs      (s_set_coeffs),
        .s_axis_fir_tready (s_axis_fir_tready),
        .m_axis_fir_tdata  (m_axis_fir_tdata),
        .m_axis_fir_tvalid (m_axis_fir_tvalid),
        .m_axis_fir_tkeep  (m_axis_fir_tkeep)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int k = 0; k < NTAPS; k++) c_m[k] = '0;
        hist.delete();
        for (int k = 0; k < NTAPS - 1; k++) hist.push_back(16'sd0);
        load_cnt = 0;
        set_prev = 1'b0;
        out_m    = '0;
        vld_m    = 1'b0;
    endtask

    function automatic logic [31:0] convolve(input logic signed [15:0] din);
        logic [31:0] s;
        int p;
        p = int'(c_m[0]) * int'(din);
        s = 32'(p);
        for (int k = 1; k < NTAPS; k++) begin
            p = int'(c_m[k]) * int'(hist[k-1]);
            s = s + 32'(p);
        end
        return s;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive on negedge, update model at posedge, check #1 after.
    task automatic step(input logic set, input logic valid,
                        input logic ready, input logic signed [15:0] d);
        @(negedge clk);
        s_set_coeffs      = set;
        s_axis_fir_tvalid = valid;
        s_axis_fir_tready = ready;
        s_axis_fir_tdata  = d;
        @(posedge clk);
        if (set) begin
            if (!set_prev) load_cnt = 0;
            c_m[load_cnt % NTAPS] = d;
            load_cnt++;
            vld_m = 1'b0;
        end else if (valid && ready) begin
            out_m = convolve(d);
            hist.push_front(d);
            void'(hist.pop_back());
            vld_m = 1'b1;
        end else begin
            vld_m = 1'b0;
        end
        set_prev = set;
        #1;
        check("tdata", m_axis_fir_tdata, out_m);
        check("tvalid", {31'd0, m_axis_fir_tvalid}, {31'd0, vld_m});
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 16'sd0);
    endtask

    initial begin
        s_set_coeffs      = 1'b0;
        s_axis_fir_tvalid = 1'b0;
        s_axis_fir_tready = 1'b0;
        s_axis_fir_tdata  = '0;
        reset             = 1'b1;
        model_reset();
        #12;
        check("rst_tdata", m_axis_fir_tdata, 32'd0);
        check("rst_tvalid", {31'd0, m_axis_fir_tvalid}, 32'd0);
        check("tkeep", {28'd0, m_axis_fir_tkeep}, 32'hF);
        @(negedge clk);
        reset = 1'b0;

        // Reset coefficients give zero output
        step(1'b0, 1'b1, 1'b1, 16'sd1234);
        check("zero_coef", m_axis_fir_tdata, 32'd0);
        step(1'b0, 1'b1, 1'b1, -16'sd500);

        // Impulse response with a backpressure gap
        step(1'b1, 1'b0, 1'b0, 16'sd7);
        step(1'b1, 1'b0, 1'b0, 16'sh003B);
        step(1'b1, 1'b0, 1'b0, 16'sh001B);
        idle();
        for (int i = 0; i < NTAPS; i++) step(1'b0, 1'b1, 1'b1, 16'sd0);
        check("flush", m_axis_fir_tdata, 32'd0);
        step(1'b0, 1'b1, 1'b1, 16'sd1);
        check("imp0", m_axis_fir_tdata, 32'd7);
        step(1'b0, 1'b1, 1'b1, 16'sd0);
        check("imp1", m_axis_fir_tdata, 32'd59);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'sd0);
            check("bp_hold", m_axis_fir_tdata, 32'd59);
            check("bp_vld", {31'd0, m_axis_fir_tvalid}, 32'd0);
        end
        step(1'b0, 1'b1, 1'b1, 16'sd0);
        check("imp2", m_axis_fir_tdata, 32'd27);
        step(1'b0, 1'b1, 1'b1, 16'sd0);
        check("imp3", m_axis_fir_tdata, 32'd0);

        // Full load with wrap: c0=9, c1..7=2..8, step settles to 44
        for (int v = 1; v <= NTAPS + 1; v++)
            step(1'b1, 1'b0, 1'b0, 16'(v));
        for (int i = 0; i < NTAPS; i++) step(1'b0, 1'b1, 1'b1, 16'sd1);
        check("step44", m_axis_fir_tdata, 32'd44);
        check("step44_vld", {31'd0, m_axis_fir_tvalid}, 32'd1);

        // Partial reload: only c0 changes, takes effect on next sample
        step(1'b1, 1'b0, 1'b0, 16'sd100);
        step(1'b0, 1'b1, 1'b1, 16'sd1);
        check("partial", m_axis_fir_tdata, 32'd135);

        // Overflow wraps modulo 2^32
        for (int i = 0; i < NTAPS; i++) step(1'b1, 1'b0, 1'b0, 16'sh7FFF);
        for (int i = 0; i < NTAPS; i++) step(1'b0, 1'b1, 1'b1, 16'sh7FFF);
        check("ovf", m_axis_fir_tdata, 32'hFFF80008);

        // Load mode has priority over a valid sample
        step(1'b1, 1'b1, 1'b1, 16'sd3);
        check("prio_vld", {31'd0, m_axis_fir_tvalid}, 32'd0);
        check("prio_hold", m_axis_fir_tdata, 32'hFFF80008);
        step(1'b0, 1'b1, 1'b1, 16'sd2);

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            logic st;
            st = ($urandom_range(0, 9) == 0) || (s_set_coeffs && $urandom_range(0, 2) != 0);
            step(st, 1'($urandom), ($urandom_range(0, 3) != 0), 16'($urandom));
        end

        // Asynchronous reset mid-stream
        step(1'b1, 1'b0, 1'b0, 16'sd5);
        step(1'b1, 1'b0, 1'b0, 16'sd6);
        step(1'b0, 1'b1, 1'b1, 16'sd9);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("arst_tdata", m_axis_fir_tdata, 32'd0);
        check("arst_tvalid", {31'd0, m_axis_fir_tvalid}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b0, 1'b1, 1'b1, 16'sd77);
        check("post_rst_zero", m_axis_fir_tdata, 32'd0);
        step(1'b1, 1'b0, 1'b0, 16'sd4);
        step(1'b0, 1'b1, 1'b1, 16'sd3);
        check("post_rst_c0", m_axis_fir_tdata, 32'd12);

        // Random tail after reset
        for (int i = 0; i < 100; i++) begin
            logic st;
            st = ($urandom_range(0, 7) == 0);
            step(st, 1'($urandom), 1'($urandom), 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
